// File: rtl/tap_window_sum.sv
// tap_window_sum: sums the eight taps of an upstream delay line through a
// pipelined adder tree and presents the window sum and average. A fill
// tracker holds results back until the window contains eight real samples.
// A result accepted at edge n appears on Sum/Avg/OutValid at edge n+3.
module tap_window_sum #(
  parameter int W            = 16,
  parameter bit AVG_ROUND    = 1'b0,
  parameter bit EMIT_PARTIAL = 1'b0
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Clear,
  input  logic         InValid,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] C,
  input  logic [W-1:0] D,
  input  logic [W-1:0] E,
  input  logic [W-1:0] F,
  input  logic [W-1:0] G,
  input  logic [W-1:0] H,
  output logic [W+2:0] Sum,
  output logic [W-1:0] Avg,
  output logic         OutValid,
  output logic         Full
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    RUNNING = 2'd2
  } fill_state_t;

  // Rounding offset added before the divide-by-eight. The largest possible
  // total plus 4 still fits in W+3 bits, so no extra width is needed.
  localparam logic [W+2:0] RND = (W+3)'(AVG_ROUND ? 4 : 0);

  fill_state_t state;
  logic [3:0]  cnt;

  logic accept;
  logic complete;
  logic v1, v2, v3;

  logic [W:0]   sum_ab, sum_cd, sum_ef, sum_gh;
  logic [W+1:0] sum_abcd, sum_efgh;
  logic [W+2:0] total;

  // A sample counts only when it is not discarded by a simultaneous Clear.
  assign accept   = InValid & ~Clear;
  // The 8th and every later accepted sample closes a window of real data.
  assign complete = (cnt == 4'd7) || (state == RUNNING);

  // Fill tracker: counts accepted samples up to eight and drives Full.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= EMPTY;
      cnt   <= 4'd0;
      Full  <= 1'b0;
    end else if (Clear) begin
      state <= EMPTY;
      cnt   <= 4'd0;
      Full  <= 1'b0;
    end else if (InValid) begin
      case (state)
        EMPTY: begin
          state <= FILLING;
          cnt   <= 4'd1;
        end
        FILLING: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            state <= RUNNING;
            Full  <= 1'b1;
          end
        end
        RUNNING: begin
          cnt  <= 4'd8;
          Full <= 1'b1;
        end
        default: begin
          state <= EMPTY;
          cnt   <= 4'd0;
          Full  <= 1'b0;
        end
      endcase
    end
  end

  // Valid bits travel alongside the adder tree; Clear drops everything in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      OutValid <= 1'b0;
    end else begin
      v1       <= accept & (complete | EMIT_PARTIAL);
      v2       <= v1 & ~Clear;
      v3       <= v2 & ~Clear;
      OutValid <= v3 & ~Clear;
    end
  end

  // Adder tree: pairwise sums, then pairs of pairs, then the window total.
  // NOTE: datapath registers carry no reset; their contents are only used
  // when the matching valid bit is set, and the valid bits are reset.
  always_ff @(posedge Clock) begin
    sum_ab   <= {1'b0, A} + {1'b0, B};
    sum_cd   <= {1'b0, C} + {1'b0, D};
    sum_ef   <= {1'b0, E} + {1'b0, F};
    sum_gh   <= {1'b0, G} + {1'b0, H};
    sum_abcd <= {1'b0, sum_ab} + {1'b0, sum_cd};
    sum_efgh <= {1'b0, sum_ef} + {1'b0, sum_gh};
    total    <= {1'b0, sum_abcd} + {1'b0, sum_efgh};
  end

  // Result registers load only for a valid window and hold otherwise.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Sum <= '0;
      Avg <= '0;
    end else if (v3 && !Clear) begin
      Sum <= total;
      Avg <= W'((total + RND) >> 3);
    end
  end

endmodule
